// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus of ram_arbiter; master = requesters, slave = arbiter.
interface ram_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 14
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        we;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM among NUM_REQ requesters.
// Define RAM_ARB_CLEAR_EN to include the bulk zero-fill engine (CLEAR state).
module ram_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 14,
   parameter int DEPTH   = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_arbiter_if.slave      bus,
   input  logic              i_clr_start,
   output logic              o_clr_busy,
   output logic              o_clr_done,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_d,
   output logic              o_ram_wren,
   input  logic [DATA_W-1:0] i_ram_q
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(DEPTH);
   logic [PTR_W-1:0]   r_ptr, w_idx;
   logic [NUM_REQ-1:0] r_rvalid, w_gnt;
   logic               w_en, w_any, w_clr;
   logic [ADDR_W-1:0]  w_clr_addr;
   function automatic logic [PTR_W-1:0] wrap(input int v);
      return PTR_W'(v >= NUM_REQ ? v - NUM_REQ : v);
   endfunction
`ifdef RAM_ARB_CLEAR_EN
   typedef enum logic {ARB, CLEAR} state_t;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy, r_done;
   assign w_clr      = r_state == CLEAR;
   assign w_en       = rst_n && !w_clr;
   assign w_clr_addr = ADDR_W'(r_cnt);
   assign o_clr_busy = r_busy;
   assign o_clr_done = r_done;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_clr) begin
            if (r_cnt == CNT_W'(DEPTH - 1)) begin
               r_state <= ARB;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else
               r_cnt <= r_cnt + 1'b1;
         end else if (i_clr_start) begin
            r_state <= CLEAR;
            r_busy  <= 1'b1;
         end
      end
   end
`else
   logic [CNT_W:0] w_unused;
   assign w_unused   = {CNT_W'(0), i_clr_start};
   assign w_clr      = 1'b0;
   assign w_en       = rst_n;
   assign w_clr_addr = '0;
   assign o_clr_busy = 1'b0;
   assign o_clr_done = 1'b0;
`endif
   // Descending scan so the port nearest r_ptr is the last (winning) assignment.
   always_comb begin
      w_idx = r_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req[wrap(int'(r_ptr) + k)]) w_idx = wrap(int'(r_ptr) + k);
      w_any = w_en && |bus.req;
      w_gnt = w_any ? NUM_REQ'(1) << w_idx : '0;
   end
   assign bus.gnt    = w_gnt;
   assign bus.rvalid = r_rvalid;
   assign bus.rdata  = i_ram_q;
   assign o_ram_wren = w_clr || (w_any && bus.we[w_idx]);
   assign o_ram_addr = w_clr ? w_clr_addr : w_any ? bus.addr[int'(w_idx)*ADDR_W +: ADDR_W] : '0;
   assign o_ram_d    = w_any ? bus.wdata[int'(w_idx)*DATA_W +: DATA_W] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_rvalid <= '0;
      end else begin
         r_rvalid <= w_gnt & ~bus.we;
         if (w_any) r_ptr <= wrap(int'(w_idx) + 1);
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;
   localparam int N = 2, DW = 32, AW = 14, DEPTH = 256;
   logic clk = 0, rst_n = 0, clr_start = 0;
   logic clr_busy, clr_done, ram_wren;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_d, ram_q;
   logic [N-1:0]  req = '0, we = '0, last_g = '0;
   logic [AW-1:0] a[N];
   logic [DW-1:0] wd[N];
   logic [DW-1:0] ram[DEPTH];
   logic [DW-1:0] ref_mem[DEPTH];
   typedef struct {int cyc; int port; logic [DW-1:0] data;} exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0, n_tests = 0, n_fail = 0, ref_ptr = 0, m_cnt = 0;
   bit   m_clr = 0, m_done = 0;

   ram_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus();
   ram_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .i_clr_start(clr_start),
      .o_clr_busy(clr_busy), .o_clr_done(clr_done), .o_ram_addr(ram_addr),
      .o_ram_d(ram_d), .o_ram_wren(ram_wren), .i_ram_q(ram_q));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM: 1-cycle registered read, q untouched by writes.
   always @(posedge clk)
      if (ram_wren) ram[ram_addr[7:0]] <= ram_d;
      else ram_q <= ram[ram_addr[7:0]];

   always_comb begin
      bus.req = req;
      bus.we  = we;
      bus.addr = '0;
      bus.wdata = '0;
      for (int i = 0; i < N; i++) begin
         bus.addr[i*AW +: AW]  = a[i];
         bus.wdata[i*DW +: DW] = wd[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every rvalid pulse must match the oldest outstanding read.
   always @(negedge clk) if (rst_n) begin
      if (bus.rvalid != '0) begin
         if (sb.size() == 0) chk("rvalid spurious", bus.rvalid, '0);
         else begin
            mon_e = sb.pop_front();
            chk("rvalid port", bus.rvalid, N'(1) << mon_e.port);
            chk("rdata", bus.rdata, mon_e.data);
            chk("rvalid latency", cyc, mon_e.cyc);
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         chk("rvalid missing", bus.rvalid, N'(1) << mon_e.port);
      end
   end

   // One clock: predict this cycle from the reference model, compare, advance the model.
   task automatic step();
      logic [N-1:0] eg;
      int gp;
      @(negedge clk);
      eg = '0;
      gp = 0;
      if (!m_clr)
         for (int k = 0; k < N; k++)
            if (eg == '0 && req[(ref_ptr + k) % N]) begin
               gp = (ref_ptr + k) % N;
               eg = N'(1) << gp;
            end
      chk("gnt", bus.gnt, eg);
      chk("clr_busy", clr_busy, m_clr);
      chk("clr_done", clr_done, m_done);
      if (m_clr) begin
         chk("clr wren", ram_wren, 1);
         chk("clr addr", ram_addr, m_cnt);
         chk("clr data", ram_d, 0);
      end else if (eg != '0) begin
         chk("ram addr", ram_addr, a[gp]);
         chk("ram wren", ram_wren, we[gp]);
         chk("ram d", ram_d, wd[gp]);
      end else begin
         chk("idle addr", ram_addr, 0);
         chk("idle wren", ram_wren, 0);
         chk("idle d", ram_d, 0);
      end
      m_done = 0;
      if (eg != '0) begin
         if (we[gp]) ref_mem[a[gp][7:0]] = wd[gp];
         else sb.push_back('{cyc: cyc + 1, port: gp, data: ref_mem[a[gp][7:0]]});
         ref_ptr = (gp + 1) % N;
      end
`ifdef RAM_ARB_CLEAR_EN
      if (m_clr) begin
         ref_mem[m_cnt] = '0;
         if (m_cnt == DEPTH - 1) begin
            m_clr = 0;
            m_cnt = 0;
            m_done = 1;
         end else m_cnt++;
      end else if (clr_start) m_clr = 1;
`endif
      last_g = eg;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      req = '1;
      we = '1;
      #1;
      chk("rst gnt", bus.gnt, '0);
      chk("rst wren", ram_wren, 0);
      chk("rst rvalid", bus.rvalid, '0);
      chk("rst busy", clr_busy, 0);
      chk("rst done", clr_done, 0);
      sb.delete();
      ref_ptr = 0;
      m_clr = 0;
      m_cnt = 0;
      m_done = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      req = '0;
      we = '0;
      rst_n = 1;
   endtask

   task automatic xfer(input int p, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      int n = 0;
      req = '0;
      req[p] = 1;
      we[p] = w;
      a[p] = ad;
      wd[p] = d;
      do begin
         step();
         n++;
      end while (!last_g[p] && n < 600);
      req[p] = 0;
   endtask

   task automatic idle(input int n);
      req = '0;
      repeat (n) step();
   endtask

   task automatic rand_update(input int drop_pct);
      for (int i = 0; i < N; i++)
         if (last_g[i] || !req[i]) begin
            req[i] = $urandom_range(99) < 70;
            we[i] = 1'($urandom_range(1));
            a[i] = AW'($urandom_range(15));
            wd[i] = $urandom;
         end else if ($urandom_range(99) < drop_pct) req[i] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < N; i++) begin
         a[i] = '0;
         wd[i] = '0;
      end
      do_reset();
      xfer(0, 1, 14'h05, 32'hDEADBEEF);
      xfer(0, 0, 14'h05, '0);
      idle(2);
      for (int i = 0; i < 16; i++) xfer(i % N, 1, AW'(i), $urandom);
      req = '1;
      we = '0;
      for (int i = 0; i < N; i++) a[i] = AW'($urandom_range(15));
      repeat (8) begin
         step();
         for (int i = 0; i < N; i++) if (last_g[i]) a[i] = AW'($urandom_range(15));
      end
      idle(2);
      for (int i = 0; i < 3; i++) xfer(1, 0, AW'(i), '0);
      req = '1;
      we = '0;
      #1 chk("rr wrap gnt", bus.gnt, 2'b01);
      step();
      step();
      idle(2);
      rand_update(0);
      repeat (400) begin
         step();
         rand_update(10);
      end
      idle(3);
`ifdef RAM_ARB_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) xfer(i % N, 1, AW'(i), 32'hA5A5A5A5);
      req = '0;
      req[0] = 1;
      we[0] = 0;
      a[0] = 14'd3;
      clr_start = 1;
      step();
      clr_start = 0;
      req[0] = 0;
      req[1] = 1;
      we[1] = 0;
      a[1] = 14'd255;
      n = 0;
      while (m_clr && n < 300) begin
         clr_start = n == 50;
         step();
         n++;
      end
      clr_start = 0;
      chk("clear length", n, DEPTH);
      chk("held port1 gnt after clear", bus.gnt, 2'b10);
      step();
      req[1] = 0;
      idle(3);
      clr_start = 1;
      step();
      clr_start = 0;
      while (m_cnt < 100) step();
      do_reset();
      idle(3);
      clr_start = 1;
      step();
      clr_start = 0;
      n = 0;
      while ((m_clr || m_done) && n < 300) begin
         step();
         n++;
      end
      xfer(0, 0, 14'd200, '0);
`else
      clr_start = 1;
      req = '1;
      we = '0;
      repeat (4) begin
         step();
         for (int i = 0; i < N; i++) if (last_g[i]) a[i] = AW'($urandom_range(15));
      end
      clr_start = 0;
`endif
      idle(3);
      chk("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
